// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common -- shared types for the pipeline hazard sequencer.
//   ctrl_state_e : sequencer FSM states (also exported on hazard_ctrl.ctrl_state)
//   stage_e      : pipeline stage index, used to address per-stage control bits
//   MDU_MAX_CYC_DFLT / PERF_W_DFLT : default parameter values
// Optional feature macro: HAZARD_PERF_EN (performance counter width default).
// -----------------------------------------------------------------------------
package common;

  localparam int MDU_MAX_CYC_DFLT = 64;
`ifdef HAZARD_PERF_EN
  localparam int PERF_W_DFLT      = 32;
`endif

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

  localparam int STG_N = 5;

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt -- saturating event counter for hazard_ctrl statistics.
// Present only when HAZARD_PERF_EN is defined.
//   clk    in  core clock
//   rst_n  in  asynchronous active-low reset, clears the count
//   i_inc  in  count one event this cycle
//   o_cnt  out current count, sticks at all-ones
// -----------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  output logic [PERF_W-1:0] o_cnt
);

  logic [PERF_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + PERF_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline sequencer for the 5-stage core.
// Produces per-stage stall (hold) and flush (bubble) controls for what operand
// forwarding cannot cover: load-use, multi-cycle MDU ops, data-memory wait
// states and EX branch redirects. Priority: mem wait > MDU > redirect > load-use.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_rs1_id/id_rs2_id [4:0]      ID source register indices
//   id_use_rs1/id_use_rs2          ID instruction actually reads rs1/rs2
//   ex_rdst_id [4:0]               EX destination register index
//   ex_mem_read                    EX instruction is a load
//   ex_mdu_op                      EX instruction is a multi-cycle MDU op
//   mdu_done                       MDU result valid (pulse)
//   ex_redirect                    EX branch/jump taken
//   mem_req, mem_ready             MEM-stage access and its completion
//   stall_if/id/ex/mem             hold stage register
//   flush_id/ex/mem/wb             load bubble into stage register
//   mdu_start                      pulse launching the MDU
//   mdu_timeout                    pulse, MDU watchdog abort
//   ctrl_state [1:0]               current ctrl_state_e (debug)
//   perf_stall_cyc/perf_flush_cnt  [PERF_W-1:0], only with HAZARD_PERF_EN
//
// Optional feature macro: HAZARD_PERF_EN adds saturating counters of IF-stall
// cycles and redirect flushes.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import common::*;
#(
  parameter int MDU_MAX_CYC = MDU_MAX_CYC_DFLT
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W      = PERF_W_DFLT
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_id,
  input  logic [4:0] id_rs2_id,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rdst_id,
  input  logic       ex_mem_read,
  input  logic       ex_mdu_op,
  input  logic       mdu_done,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       flush_wb,
  output logic       mdu_start,
  output logic       mdu_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MDU_MAX_CYC);

  ctrl_state_e      r_state, w_state_nxt;
  ctrl_state_e      r_resume, w_resume_nxt;   // state to return to after a mem wait
  ctrl_state_e      w_eff;                    // state whose rules apply this cycle
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;         // MDU wait cycles, frozen during mem waits
  logic             r_done_q, w_done_q_nxt;   // mdu_done seen while parked in a mem wait

  logic [STG_N-1:0] w_stall, w_flush;
  logic             w_mdu_start, w_mdu_timeout, w_redirect_hit;
  logic             w_mem_stall, w_load_use, w_cnt_last;

  assign w_mem_stall = mem_req && !mem_ready;
  assign w_cnt_last  = (r_cnt == CNT_W'(MDU_MAX_CYC - 1));
  assign w_load_use  = ex_mem_read && (ex_rdst_id != 5'd0) &&
                       ((id_use_rs1 && (id_rs1_id == ex_rdst_id)) ||
                        (id_use_rs2 && (id_rs2_id == ex_rdst_id)));

  // The cycle mem_ready ends a wait is decided by the rules of the state we
  // resume into, so the wait state itself never drives outputs on exit.
  assign w_eff = (r_state == ST_MEM_WAIT) ? r_resume : r_state;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    w_stall        = '0;
    w_flush        = '0;
    w_mdu_start    = 1'b0;
    w_mdu_timeout  = 1'b0;
    w_redirect_hit = 1'b0;
    w_state_nxt    = ST_RUN;
    w_resume_nxt   = r_resume;
    w_cnt_nxt      = r_cnt;
    w_done_q_nxt   = r_done_q;

    if (w_mem_stall) begin
      // Freeze IF..MEM and bubble WB; the MDU op (if any) stays parked in EX.
      w_stall[STG_IF]  = 1'b1;
      w_stall[STG_ID]  = 1'b1;
      w_stall[STG_EX]  = 1'b1;
      w_stall[STG_MEM] = 1'b1;
      w_flush[STG_WB]  = 1'b1;
      w_state_nxt      = ST_MEM_WAIT;
      w_resume_nxt     = w_eff;
      if ((w_eff == ST_MDU_WAIT) && mdu_done) begin
        w_done_q_nxt = 1'b1;
      end
    end else begin
      unique case (w_eff)
        ST_MDU_WAIT: begin
          if (mdu_done || r_done_q) begin
            w_done_q_nxt = 1'b0;
          end else if (w_cnt_last) begin
            // Drop the stuck op: bubble EX and hold the stages behind it.
            w_mdu_timeout   = 1'b1;
            w_stall[STG_IF] = 1'b1;
            w_stall[STG_ID] = 1'b1;
            w_flush[STG_EX] = 1'b1;
          end else begin
            w_stall[STG_IF]  = 1'b1;
            w_stall[STG_ID]  = 1'b1;
            w_stall[STG_EX]  = 1'b1;
            w_flush[STG_MEM] = 1'b1;
            w_cnt_nxt        = r_cnt + CNT_W'(1);
            w_state_nxt      = ST_MDU_WAIT;
          end
        end
        default: begin
          if (ex_mdu_op) begin
            w_mdu_start      = 1'b1;
            w_stall[STG_IF]  = 1'b1;
            w_stall[STG_ID]  = 1'b1;
            w_stall[STG_EX]  = 1'b1;
            w_flush[STG_MEM] = 1'b1;
            w_cnt_nxt        = '0;
            w_state_nxt      = ST_MDU_WAIT;
          end else if (ex_redirect) begin
            // IF fetches the new target, so nothing is held; the load-use
            // check is moot because the ID instruction is squashed.
            w_redirect_hit  = 1'b1;
            w_flush[STG_ID] = 1'b1;
            w_flush[STG_EX] = 1'b1;
          end else if (w_load_use) begin
            w_stall[STG_IF] = 1'b1;
            w_stall[STG_ID] = 1'b1;
            w_flush[STG_EX] = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_resume <= ST_RUN;
      r_cnt    <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done_q <= w_done_q_nxt;
    end
  end

  // NOTE: the controls are combinational from the inputs, so they are gated
  // with rst_n to be quiet for the whole time reset is held, not just after
  // the state flops clear.
  assign stall_if    = rst_n && w_stall[STG_IF];
  assign stall_id    = rst_n && w_stall[STG_ID];
  assign stall_ex    = rst_n && w_stall[STG_EX];
  assign stall_mem   = rst_n && w_stall[STG_MEM];
  assign flush_id    = rst_n && w_flush[STG_ID];
  assign flush_ex    = rst_n && w_flush[STG_EX];
  assign flush_mem   = rst_n && w_flush[STG_MEM];
  assign flush_wb    = rst_n && w_flush[STG_WB];
  assign mdu_start   = rst_n && w_mdu_start;
  assign mdu_timeout = rst_n && w_mdu_timeout;
  assign ctrl_state  = r_state;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall[STG_IF]),
    .o_cnt (perf_stall_cyc)
  );

  hazard_perf_cnt #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_redirect_hit),
    .o_cnt (perf_flush_cnt)
  );
`endif

  // An MDU op and a taken redirect both claiming EX means upstream decode is
  // broken; the MDU wins, but it should never happen.
  a_mdu_vs_redirect: assert property (@(posedge clk) disable iff (!rst_n)
    !((w_eff == ST_RUN) && !w_mem_stall && ex_mdu_op && ex_redirect));

  // A stage is never held and bubbled at once; IF has no flush, WB no stall.
  a_stall_flush_excl: assert property (@(posedge clk) disable iff (!rst_n)
    ((w_stall & w_flush) == '0) && !w_stall[STG_WB] && !w_flush[STG_IF]);

endmodule
